// File: rtl/mdr_load_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mdr_load_unit
//  Description : Memory-data-register load unit. Accepts a word, halfword or
//                byte load request, checks its alignment, issues a single
//                registered memory read strobe, and waits MEM_LATENCY cycles
//                for the read data. It then extracts the addressed byte and
//                halfword (big-endian lanes) and a zero-extended load result.
//                Misaligned requests skip the memory access entirely and are
//                reported through align_err alongside load_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdr_load_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [1:0]  load_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_data_in,
  output logic        mem_rd,
  output logic [7:0]  mdr_byte,
  output logic [15:0] mdr_half,
  output logic [31:0] load_data,
  output logic        load_done,
  output logic        align_err,
  output logic        busy
);

  // The wait counter is only 3 bits wide, so the latency must fit in 1..7.
  if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_latency_check
    $error("mdr_load_unit: MEM_LATENCY must be in the range 1..7");
  end

  localparam logic [2:0] c_lat_init  = 3'(MEM_LATENCY);
  localparam logic [1:0] c_type_word = 2'b00;
  localparam logic [1:0] c_type_half = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_type;
  logic [1:0]  r_addr;
  logic [2:0]  r_cnt;
  logic        r_mem_rd;
  logic        r_load_done;
  logic        r_align_err;
  logic [7:0]  r_byte;
  logic [15:0] r_half;
  logic [31:0] r_data;

  logic        w_req_misaligned;
  logic        w_capture;
  logic        w_err_next;
  logic [7:0]  w_sel_byte;
  logic [15:0] w_sel_half;
  logic [31:0] w_sel_data;

  // Alignment of the incoming request: bytes are always aligned, reserved
  // type 11 behaves as a byte.
  always_comb begin
    w_req_misaligned = 1'b0;
    if (load_type == c_type_word) begin
      w_req_misaligned = (addr_lo != 2'b00);
    end else if (load_type == c_type_half) begin
      w_req_misaligned = addr_lo[0];
    end
  end

  // Next-state logic; capture fires on the last WAIT cycle.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          if (w_req_misaligned) begin
            w_next_state = ST_DONE;
            w_err_next   = 1'b1;
          end else begin
            w_next_state = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // A count of zero cannot occur here; treating it like one keeps the
        // FSM from stalling if it ever did.
        if (r_cnt <= 3'd1) begin
          w_capture    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Big-endian lane selection driven by the latched address.
  always_comb begin
    w_sel_byte = mem_data_in[31:24];
    case (r_addr)
      2'b00:   w_sel_byte = mem_data_in[31:24];
      2'b01:   w_sel_byte = mem_data_in[23:16];
      2'b10:   w_sel_byte = mem_data_in[15:8];
      default: w_sel_byte = mem_data_in[7:0];
    endcase
    w_sel_half = r_addr[1] ? mem_data_in[15:0] : mem_data_in[31:16];
    if (r_type == c_type_word) begin
      w_sel_data = mem_data_in;
    end else if (r_type == c_type_half) begin
      w_sel_data = {16'b0, w_sel_half};
    end else begin
      w_sel_data = {24'b0, w_sel_byte};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latch and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_type <= 2'b00;
      r_addr <= 2'b00;
      r_cnt  <= 3'd0;
    end else begin
      if (r_state == ST_IDLE && load_start) begin
        r_type <= load_type;
        r_addr <= addr_lo;
      end
      if (r_state == ST_REQ) begin
        r_cnt <= c_lat_init;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Registered strobes, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_rd    <= 1'b0;
      r_load_done <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_mem_rd    <= (w_next_state == ST_REQ);
      r_load_done <= (w_next_state == ST_DONE);
      r_align_err <= (w_next_state == ST_DONE) && w_err_next;
    end
  end

  // Data outputs change only on capture and otherwise hold between loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte <= 8'h00;
      r_half <= 16'h0000;
      r_data <= 32'h0000_0000;
    end else if (w_capture) begin
      r_byte <= w_sel_byte;
      r_half <= w_sel_half;
      r_data <= w_sel_data;
    end
  end

  assign mem_rd    = r_mem_rd;
  assign load_done = r_load_done;
  assign align_err = r_align_err;
  assign mdr_byte  = r_byte;
  assign mdr_half  = r_half;
  assign load_data = r_data;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mdr_load_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mdr_load_unit
//  Description : Self-checking bench for mdr_load_unit. Two instances
//                (latency 1 and 4) share one stimulus stream; a cycle-count
//                transaction model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdr_load_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [1:0]  load_type = 2'b00;
  logic [1:0]  addr_lo = 2'b00;
  logic [31:0] mem_data_in = 32'h0;

  logic [1:0]       o_rd, o_done, o_al, o_busy;
  logic [1:0][7:0]  o_byte;
  logic [1:0][15:0] o_half;
  logic [1:0][31:0] o_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdr_load_unit #(.MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_type(load_type),
    .addr_lo(addr_lo), .mem_data_in(mem_data_in), .mem_rd(o_rd[0]),
    .mdr_byte(o_byte[0]), .mdr_half(o_half[0]), .load_data(o_data[0]),
    .load_done(o_done[0]), .align_err(o_al[0]), .busy(o_busy[0])
  );

  mdr_load_unit #(.MEM_LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_type(load_type),
    .addr_lo(addr_lo), .mem_data_in(mem_data_in), .mem_rd(o_rd[1]),
    .mdr_byte(o_byte[1]), .mdr_half(o_half[1]), .load_data(o_data[1]),
    .load_done(o_done[1]), .align_err(o_al[1]), .busy(o_busy[1])
  );

  // ---------------- transaction model ----------------
  int          cyc = 0;
  int          lat [2] = '{1, 4};
  bit          act [2] = '{1'b0, 1'b0};
  int          rd_c [2] = '{-1, -1};
  int          cap_c [2] = '{-1, -1};
  int          done_c [2] = '{-1, -1};
  bit          m_mis [2] = '{1'b0, 1'b0};
  logic [1:0]  m_type [2] = '{2'b00, 2'b00};
  logic [1:0]  m_addr [2] = '{2'b00, 2'b00};
  logic [7:0]  e_byte [2] = '{8'h0, 8'h0};
  logic [15:0] e_half [2] = '{16'h0, 16'h0};
  logic [31:0] e_data [2] = '{32'h0, 32'h0};

  int last_rd [2] = '{-100, -100};
  int last_done [2] = '{-100, -100};
  int last_al [2] = '{-100, -100};
  int n_done [2] = '{0, 0};

  function automatic logic [7:0] f_byte(input logic [31:0] d, input logic [1:0] a);
    logic [31:0] t;
    t = d >> (8 * (3 - int'(a)));
    return t[7:0];
  endfunction

  function automatic logic [15:0] f_half(input logic [31:0] d, input logic [1:0] a);
    logic [31:0] t;
    t = d >> (a[1] ? 0 : 16);
    return t[15:0];
  endfunction

  function automatic bit f_mis(input logic [1:0] t, input logic [1:0] a);
    if (t == 2'b00) return (a != 2'b00);
    if (t == 2'b01) return a[0];
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act_v, exp_v, $time);
    end
  endtask

  // Model advance at each rising edge using the inputs present at that edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        act[k] = 1'b0;
        e_byte[k] = 8'h0;
        e_half[k] = 16'h0;
        e_data[k] = 32'h0;
      end else begin
        if (act[k] && cyc == cap_c[k]) begin
          e_byte[k] = f_byte(mem_data_in, m_addr[k]);
          e_half[k] = f_half(mem_data_in, m_addr[k]);
          if (m_type[k] == 2'b00)      e_data[k] = mem_data_in;
          else if (m_type[k] == 2'b01) e_data[k] = {16'h0, e_half[k]};
          else                         e_data[k] = {24'h0, e_byte[k]};
        end
        if (act[k] && cyc == done_c[k]) begin
          act[k] = 1'b0;
        end else if (!act[k] && load_start) begin
          act[k]    = 1'b1;
          m_type[k] = load_type;
          m_addr[k] = addr_lo;
          m_mis[k]  = f_mis(load_type, addr_lo);
          if (m_mis[k]) begin
            rd_c[k] = -1; cap_c[k] = -1; done_c[k] = cyc + 1;
          end else begin
            rd_c[k] = cyc + 1; cap_c[k] = cyc + 1 + lat[k]; done_c[k] = cyc + 2 + lat[k];
          end
        end
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic e_rd, e_done, e_al, e_busy;
      e_rd   = !reset && act[k] && (cyc == rd_c[k]);
      e_done = !reset && act[k] && (cyc == done_c[k]);
      e_al   = e_done && m_mis[k];
      e_busy = !reset && act[k];
      chk($sformatf("mem_rd[%0d]", k), {31'b0, o_rd[k]}, {31'b0, e_rd});
      chk($sformatf("load_done[%0d]", k), {31'b0, o_done[k]}, {31'b0, e_done});
      chk($sformatf("align_err[%0d]", k), {31'b0, o_al[k]}, {31'b0, e_al});
      chk($sformatf("busy[%0d]", k), {31'b0, o_busy[k]}, {31'b0, e_busy});
      chk($sformatf("mdr_byte[%0d]", k), {24'b0, o_byte[k]}, reset ? 32'h0 : {24'b0, e_byte[k]});
      chk($sformatf("mdr_half[%0d]", k), {16'b0, o_half[k]}, reset ? 32'h0 : {16'b0, e_half[k]});
      chk($sformatf("load_data[%0d]", k), o_data[k], reset ? 32'h0 : e_data[k]);
      if (o_rd[k]) last_rd[k] = cyc;
      if (o_al[k]) last_al[k] = cyc;
      if (o_done[k]) begin
        last_done[k] = cyc;
        n_done[k]++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] t, input logic [1:0] a, input logic [31:0] d, output int c0);
    load_type   = t;
    addr_lo     = a;
    mem_data_in = d;
    load_start  = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0;
    int nd0, nd1;

    // Reset state
    idle(3);
    chk("reset load_data", o_data[0], 32'h0);
    chk("reset busy", {31'b0, o_busy[1]}, 32'h0);
    reset = 1'b0;

    // Word load accepted on the first edge after reset release
    go(2'b00, 2'b00, 32'hDEADBEEF, c0);
    idle(9);
    chk("model word data", e_data[0], 32'hDEADBEEF);
    chk("word load_data L1", o_data[0], 32'hDEADBEEF);
    chk("word mdr_half L1", {16'b0, o_half[0]}, 32'h0000DEAD);
    chk("word mdr_byte L1", {24'b0, o_byte[0]}, 32'h000000DE);
    chk("word load_data L4", o_data[1], 32'hDEADBEEF);
    chk("word rd cycle L1", 32'(last_rd[0] - c0), 32'd1);
    chk("word done cycle L1", 32'(last_done[0] - c0), 32'd3);
    chk("word rd cycle L4", 32'(last_rd[1] - c0), 32'd1);
    chk("word done cycle L4", 32'(last_done[1] - c0), 32'd6);

    // Byte loads
    go(2'b10, 2'b11, 32'h123456F0, c0);
    idle(9);
    chk("byte11 mdr_byte", {24'b0, o_byte[0]}, 32'h000000F0);
    chk("byte11 load_data", o_data[0], 32'h000000F0);
    go(2'b10, 2'b01, 32'h123456F0, c0);
    idle(9);
    chk("byte01 mdr_byte", {24'b0, o_byte[1]}, 32'h00000034);
    chk("byte01 load_data", o_data[0], 32'h00000034);

    // Halfword load
    go(2'b01, 2'b10, 32'hAAAA8001, c0);
    idle(9);
    chk("half10 mdr_half", {16'b0, o_half[0]}, 32'h00008001);
    chk("half10 load_data", o_data[0], 32'h00008001);
    chk("half10 mdr_byte", {24'b0, o_byte[1]}, 32'h00000080);

    // Misaligned halfword: done+align in cycle 1, no read, outputs held
    go(2'b01, 2'b01, 32'h55555555, c0);
    idle(4);
    chk("mis half align cycle", 32'(last_al[0] - c0), 32'd1);
    chk("mis half done cycle", 32'(last_done[0] - c0), 32'd1);
    chk("mis half no mem_rd", {31'b0, last_rd[0] < c0}, 32'd1);
    chk("mis half data held", o_data[0], 32'h00008001);
    chk("mis half half held", {16'b0, o_half[1]}, 32'h00008001);

    // Misaligned word
    go(2'b00, 2'b10, 32'h99999999, c0);
    idle(4);
    chk("mis word align cycle L4", 32'(last_al[1] - c0), 32'd1);
    chk("mis word no mem_rd L4", {31'b0, last_rd[1] < c0}, 32'd1);

    // Latency 4 with load_start pulses in cycles 2..6
    nd1 = n_done[1];
    go(2'b00, 2'b00, 32'hCAFEF00D, c0);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      load_type  = 2'b10;
      addr_lo    = 2'b11;
      load_start = 1'b1;
      idle(1);
    end
    load_start = 1'b0;
    idle(8);
    chk("L4 single done", 32'(n_done[1] - nd1), 32'd1);
    chk("L4 done cycle", 32'(last_done[1] - c0), 32'd6);
    chk("L4 word kept", o_data[1], 32'hCAFEF00D);
    chk("L1 accepted later byte", o_data[0], 32'h0000000D);

    // Reset during WAIT aborts the load
    go(2'b00, 2'b00, 32'h11223344, c0);
    idle(1);
    nd0 = n_done[0];
    nd1 = n_done[1];
    reset = 1'b1;
    #1;
    chk("abort load_data L1", o_data[0], 32'h0);
    chk("abort busy L4", {31'b0, o_busy[1]}, 32'h0);
    chk("abort mdr_half L4", {16'b0, o_half[1]}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(8);
    chk("abort no done L1", 32'(n_done[0] - nd0), 32'd0);
    chk("abort no done L4", 32'(n_done[1] - nd1), 32'd0);
    go(2'b10, 2'b01, 32'h00AB0000, c0);
    idle(9);
    chk("post-reset byte L4", {24'b0, o_byte[1]}, 32'h000000AB);
    chk("post-reset data L1", o_data[0], 32'h000000AB);
    chk("post-reset done L4", 32'(last_done[1] - c0), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdr_load_unit.md
MDR_LOAD_UNIT -- requirements
Module: mdr_load_unit

Interface
REQ-001 Parameter MEM_LATENCY, default 1, meaning: cycles from the mem_rd cycle to the cycle in which mem_data_in is valid; the legal range SHALL be 1..7.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port load_start, input, 1 bit: requests a load; it SHALL be sampled only in IDLE.
REQ-005 Port load_type, input, 2 bits: 00 word, 01 halfword, 10 byte, 11 reserved (treated as byte).
REQ-006 Port addr_lo, input, 2 bits: address bits [1:0], sampled with load_start.
REQ-007 Port mem_data_in, input, 32 bits: memory read data, big-endian (byte 0 = bits [31:24]).
REQ-008 Port mem_rd, output, 1 bit: registered memory read strobe.
REQ-009 Port mdr_byte, output, 8 bits: selected byte, feeding the sign-extend stage's 8-bit MDR input.
REQ-010 Port mdr_half, output, 16 bits: selected halfword.
REQ-011 Port load_data, output, 32 bits: the selected value zero-extended to 32 bits (the full word for word loads).
REQ-012 Port load_done, output, 1 bit: one-cycle pulse marking the outputs as updated or the load as rejected.
REQ-013 Port align_err, output, 1 bit: one-cycle pulse, coincident with load_done, on a misaligned request.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, WAIT and DONE, and a 3-bit wait counter.
REQ-016 IDLE with load_start=1 SHALL latch load_type and addr_lo; if the request is aligned, next state SHALL be REQ, otherwise DONE.
REQ-017 Alignment: a halfword with addr_lo[0]=1 or a word with addr_lo!=00 SHALL be misaligned; byte loads SHALL always be aligned.
REQ-018 REQ SHALL last one cycle with mem_rd=1, load the counter with MEM_LATENCY, then move to WAIT.
REQ-019 WAIT SHALL decrement the counter each cycle; in the cycle the counter equals 1, it SHALL capture mem_data_in and move to DONE.
REQ-020 Timing: start sampled at the end of cycle 0 -> mem_rd in cycle 1 -> capture at the end of cycle 1+MEM_LATENCY -> load_done in cycle 2+MEM_LATENCY.
REQ-021 Byte select SHALL be: addr_lo 00 -> [31:24], 01 -> [23:16], 10 -> [15:8], 11 -> [7:0].
REQ-022 Halfword select SHALL be: addr_lo 00 -> [31:16], 10 -> [15:0].
REQ-023 On capture, mdr_byte and mdr_half SHALL be loaded from the selection for the latched addr_lo, regardless of load_type.
REQ-024 On capture, load_data SHALL be loaded per load_type: {24'b0,byte}, {16'b0,half}, or the full word.
REQ-025 DONE SHALL last one cycle with load_done=1, then return to IDLE; a load_start in DONE SHALL be ignored.
REQ-026 On a misaligned request, mem_rd SHALL never assert, data outputs SHALL hold their previous values, and align_err=1 SHALL be asserted in DONE.
REQ-027 load_start while busy=1 SHALL be ignored, with no queuing.
REQ-028 Outputs SHALL hold their values between loads.

Reset
REQ-029 While reset is asserted, state SHALL be IDLE, the counter 0, and mem_rd, load_done, align_err, busy, mdr_byte, mdr_half and load_data all 0, asynchronously and without waiting for clk.
REQ-030 Reset asserted mid-load (REQ or WAIT) SHALL abort the load: no capture, no load_done pulse, and mem_rd dropped immediately.
REQ-031 The first load_start SHALL be accepted on the first rising edge after reset is released.

Verification
REQ-032 Word load, MEM_LATENCY=1, addr_lo=00, mem_data_in=0xDEADBEEF -> mem_rd in cycle 1, load_done in cycle 3, load_data=0xDEADBEEF, mdr_half=0xDEAD, mdr_byte=0xDE.
REQ-033 Byte load, addr_lo=11, data 0x123456F0 -> mdr_byte=0xF0, load_data=0x000000F0; addr_lo=01 -> mdr_byte=0x34.
REQ-034 Halfword load, addr_lo=10, data 0xAAAA8001 -> mdr_half=0x8001, load_data=0x00008001; halfword load with addr_lo=01 -> align_err=1 and load_done=1 in cycle 1, no mem_rd, outputs unchanged.
REQ-035 MEM_LATENCY=4 -> mem_rd in cycle 1, data sampled at the end of cycle 5, load_done in cycle 6; load_start pulses in cycles 2..6 are ignored.
REQ-036 Reset asserted in WAIT -> all outputs 0 immediately and no load_done; a new byte load after release completes normally.
